ram_bus_initiator: RTL and testbench
====================================

Name: ram_bus_initiator

Overview:
- Fabric-side master for the RamBus register interface that DMMainPorts exposes as a responder.
- Converts single-word read/write commands into APB-style two-phase RamBus transactions and returns read data and status to the requester.
- Lets fabric logic (UART command parser, PPS sequencer, test master) reach DMMainPorts registers without the MSS; an upstream mux selects between this block and the MSS.
- Includes an ack timeout so a dead responder cannot hang the requester.

Parameters:
ADDR_W, 14, RamBus address width
DATA_W, 32, RamBus data width
TIMEOUT_CYCLES, 255, ACCESS-phase cycles without RamBusAck before abort (1..65535)

Ports:
clk  in  1  system clock (same clock as DMMainPorts)
nRst  in  1  reset; asynchronous, active-low
CmdValid  in  1  command offered
CmdReady  out  1  command accepted when CmdValid & CmdReady
CmdWrnRd  in  1  1 = write, 0 = read
CmdAddress  in  ADDR_W  target register address
CmdData  in  DATA_W  write data (ignored for reads)
RspValid  out  1  response available
RspReady  in  1  response consumed when RspValid & RspReady
RspData  out  DATA_W  read data; 0 for writes and timeouts
RspTimeout  out  1  1 = transaction aborted by timeout
Busy  out  1  high in any state other than IDLE
RamBusAddress  out  ADDR_W  transaction address
RamBusDataIn  out  DATA_W  write data to responder
RamBusnCs  out  1  select; high for the whole transaction (same polarity as the MSS PSEL that drives it today)
RamBusWrnRd  out  1  1 = write
RamBusLatch  out  1  enable/access phase
RamBusAck  in  1  responder ready; completes ACCESS
RamBusDataOut  in  DATA_W  responder read data

Behaviour:
- Reset (nRst low, asynchronous): state IDLE, timeout counter 0. Every output is 0, except CmdReady, which is 1 once nRst is high. Reset in mid-transaction drops RamBusnCs/RamBusLatch immediately; the command is lost and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CmdReady = 1.
  - On CmdValid, register address, data and WrnRd, then go to SETUP.
- SETUP (exactly 1 cycle):
  - RamBusnCs = 1, RamBusLatch = 0.
  - Address, DataIn and WrnRd are driven from the registered command.
  - Next state is ACCESS.
- ACCESS:
  - RamBusnCs = 1, RamBusLatch = 1; address, data and WrnRd stay stable.
  - RamBusAck is sampled each clk edge.
  - If Ack = 1:
    - read: capture RamBusDataOut into RspData;
    - write: RspData = 0;
    - RspTimeout = 0; go to RESP.
  - If Ack = 0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without Ack, set RspTimeout = 1, RspData = 0, go to RESP.
  - Ack and timeout on the same edge: Ack wins (normal completion).
- RESP:
  - RamBusnCs = 0, RamBusLatch = 0. Bus address/data hold their last values (don't-care to the responder).
  - RspValid = 1; RspData and RspTimeout are stable until the handshake.
  - On RspReady, go to IDLE and clear the counter.
- Latency:
  - Command accept to first Latch cycle: 2 clk.
  - Ack in the first ACCESS cycle gives RspValid 3 clk after the accept edge.
  - Minimum command-to-command spacing is 4 clk with RspReady tied high.
- CmdReady is 0 outside IDLE, so only one transaction is outstanding. There is no buffering.
- RamBusAck is ignored outside ACCESS.
- Busy = (state != IDLE).
- Counter is 16 bits, saturating, and cleared on entry to SETUP.
- No combinational path from any input to any output except CmdReady/Busy, which are decoded from state only.

Test Plan:
- Write 0x1234_5678 to address 0x0040, responder acks in the first ACCESS cycle.
  - Required: SETUP cycle with nCs=1, Latch=0, WrnRd=1, Addr=0x0040, DataIn=0x12345678; next cycle Latch=1.
  - Then RspValid with RspData=0, RspTimeout=0, 3 clk after accept.
- Read from 0x3FFF, responder holds Ack low 5 cycles, then Ack with DataOut=0xDEAD_BEEF.
  - Required: Latch high for 6 cycles; RspData=0xDEADBEEF, RspTimeout=0.
- TIMEOUT_CYCLES=8, responder never acks.
  - Required: Latch high exactly 8 cycles, then nCs/Latch drop; RspValid with RspTimeout=1, RspData=0.
- TIMEOUT_CYCLES=8, Ack arrives on the 8th ACCESS cycle.
  - Required: normal completion, RspTimeout=0, data captured.
- Hold RspReady low for 10 cycles, with CmdValid held high carrying a second command.
  - Required: RspValid and RspData stable for all 10 cycles; CmdReady=0 throughout.
  - The second command is accepted only after the Rsp handshake.
- Assert nRst low mid-ACCESS (asynchronously, between clk edges).
  - Required: nCs, Latch, RspValid and Busy go to 0 without a clock edge.
  - After release, CmdReady=1 and a new read completes normally.

Source files
------------

// File: rtl/ram_bus_initiator.sv
// Fabric-side RamBus master: turns single-word read/write commands into
// two-phase (SETUP/ACCESS) bus transactions with an ack timeout.
module ram_bus_initiator #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrnRd,
  input  logic [ADDR_W-1:0] CmdAddress,
  input  logic [DATA_W-1:0] CmdData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspTimeout,
  output logic              Busy,
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  output logic              RamBusnCs,
  output logic              RamBusWrnRd,
  output logic              RamBusLatch,
  input  logic              RamBusAck,
  input  logic [DATA_W-1:0] RamBusDataOut
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wrnrd_q, wrnrd_d;
  logic              ncs_q, ncs_d;
  logic              latch_q, latch_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_to_q, rsp_to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (CmdValid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (RamBusAck || (cnt_q == CNT_LAST)) state_d = ST_RESP;
      ST_RESP:   if (RspReady) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; bus strobes track the next state so they
  // line up with the state register cycle for cycle
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wrnrd_d     = wrnrd_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;
    cnt_d       = cnt_q;
    ncs_d       = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    latch_d     = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
    unique case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          addr_d  = CmdAddress;
          wdata_d = CmdData;
          wrnrd_d = CmdWrnRd;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
      end
      ST_ACCESS: begin
        if (RamBusAck) begin
          rsp_data_d = wrnrd_q ? '0 : RamBusDataOut;
          rsp_to_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_to_d   = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (RspReady) cnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wrnrd_q     <= 1'b0;
      ncs_q       <= 1'b0;
      latch_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wrnrd_q     <= wrnrd_d;
      ncs_q       <= ncs_d;
      latch_q     <= latch_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign CmdReady      = (state_q == ST_IDLE);
  assign Busy          = (state_q != ST_IDLE);
  assign RamBusAddress = addr_q;
  assign RamBusDataIn  = wdata_q;
  assign RamBusWrnRd   = wrnrd_q;
  assign RamBusnCs     = ncs_q;
  assign RamBusLatch   = latch_q;
  assign RspValid      = rsp_valid_q;
  assign RspData       = rsp_data_q;
  assign RspTimeout    = rsp_to_q;

endmodule

// File: tb/tb_ram_bus_initiator.sv
// Bench for ram_bus_initiator: table vectors, corner sequences and random
// transactions against a transaction-level model of the bus protocol.
module tb_ram_bus_initiator;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int T = 8;

  logic          clk = 1'b0;
  logic          nRst = 1'b1;
  logic          CmdValid = 1'b0;
  logic          CmdReady;
  logic          CmdWrnRd = 1'b0;
  logic [AW-1:0] CmdAddress = '0;
  logic [DW-1:0] CmdData = '0;
  logic          RspValid;
  logic          RspReady = 1'b0;
  logic [DW-1:0] RspData;
  logic          RspTimeout;
  logic          Busy;
  logic [AW-1:0] RamBusAddress;
  logic [DW-1:0] RamBusDataIn;
  logic          RamBusnCs;
  logic          RamBusWrnRd;
  logic          RamBusLatch;
  logic          RamBusAck = 1'b0;
  logic [DW-1:0] RamBusDataOut = '0;

  int checks = 0;
  int errors = 0;

  ram_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nRst(nRst),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrnRd(CmdWrnRd),
    .CmdAddress(CmdAddress), .CmdData(CmdData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspTimeout(RspTimeout), .Busy(Busy),
    .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn),
    .RamBusnCs(RamBusnCs), .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch),
    .RamBusAck(RamBusAck), .RamBusDataOut(RamBusDataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_delay;
    logic [DW-1:0] rdata;
    int            rsp_wait;
    int            exp_latch;
    logic          exp_to;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    int            latch;
    int            t_latch;
    int            t_rsp;
    logic [DW-1:0] data;
    logic          to;
    bit            bus_ok;
    bit            setup_ok;
    bit            stable;
    bit            got;
  } obs_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectations: ack after d idle ACCESS cycles unless the
  // timeout window of T cycles closes first
  function automatic void model(input logic wr, input int d, input logic [DW-1:0] rdata,
                                output int l, output logic to, output logic [DW-1:0] data);
    to   = (d >= T);
    l    = to ? T : d + 1;
    data = (to || wr) ? '0 : rdata;
  endfunction

  // Runs one command from an IDLE negedge up to the negedge after the response handshake
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ack_delay, input logic [DW-1:0] rdata, input int rsp_wait,
                         input bit keep, input logic nwr, input logic [AW-1:0] naddr,
                         input logic [DW-1:0] nwdata, output obs_t o);
    int  n;
    bit  done;
    o.latch = 0; o.t_latch = -1; o.t_rsp = -1; o.data = '0; o.to = 1'b0;
    o.bus_ok = 1'b1; o.setup_ok = 1'b0; o.stable = 1'b1; o.got = 1'b0;
    check("cmd_ready_idle", 64'(CmdReady), 64'(1));
    CmdValid = 1'b1; CmdWrnRd = wr; CmdAddress = addr; CmdData = wdata;
    @(posedge clk);
    @(negedge clk);
    CmdValid = keep; CmdWrnRd = nwr; CmdAddress = naddr; CmdData = nwdata;
    n = 1;
    done = 1'b0;
    while (!done && n < 60) begin
      if (RamBusnCs === 1'b1 &&
          (RamBusAddress !== addr || RamBusWrnRd !== wr || RamBusDataIn !== wdata))
        o.bus_ok = 1'b0;
      if (n == 1) o.setup_ok = (RamBusnCs === 1'b1 && RamBusLatch === 1'b0);
      if (RamBusLatch === 1'b1) begin
        o.latch++;
        if (o.t_latch < 0) o.t_latch = n;
        RamBusAck = (o.latch == ack_delay + 1);
        RamBusDataOut = RamBusAck ? rdata : $urandom;
      end else begin
        RamBusAck = 1'($urandom_range(0, 1));
        RamBusDataOut = $urandom;
      end
      if (RspValid === 1'b1) begin
        o.t_rsp = n; o.data = RspData; o.to = RspTimeout; o.got = 1'b1;
        if (RamBusnCs !== 1'b0 || RamBusLatch !== 1'b0) o.bus_ok = 1'b0;
        for (int k = 0; k < rsp_wait; k++) begin
          RspReady = 1'b0;
          @(negedge clk);
          if (RspValid !== 1'b1 || RspData !== o.data || RspTimeout !== o.to ||
              CmdReady !== 1'b0 || Busy !== 1'b1)
            o.stable = 1'b0;
        end
        RspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RspReady = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    RamBusAck = 1'b0;
  endtask

  task automatic check_txn(input obs_t o, input int exp_latch, input logic exp_to,
                           input logic [DW-1:0] exp_data);
    check("rsp_seen", 64'(o.got), 64'(1));
    check("setup_phase", 64'(o.setup_ok), 64'(1));
    check("bus_stable", 64'(o.bus_ok), 64'(1));
    check("accept_to_latch", 64'(o.t_latch), 64'(2));
    check("accept_to_rsp", 64'(o.t_rsp), 64'(2 + exp_latch));
    check("latch_cycles", 64'(o.latch), 64'(exp_latch));
    check("rsp_timeout", 64'(o.to), 64'(exp_to));
    check("rsp_data", 64'(o.data), 64'(exp_data));
    check("rsp_hold", 64'(o.stable), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[6];
    obs_t          o;
    int            el;
    logic          eto;
    logic [DW-1:0] ed;
    bit            quiet;

    vecs[0] = '{1'b1, 14'h0040, 32'h1234_5678, 0,   32'h0BAD_0BAD, 0, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 14'h3FFF, 32'h0000_0000, 5,   32'hDEAD_BEEF, 1, 6, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 14'h0100, 32'h0000_0000, 100, 32'hCAFE_F00D, 0, 8, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 14'h0200, 32'h0000_0000, 7,   32'hA5A5_5A5A, 2, 8, 1'b0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 14'h1555, 32'hFFFF_FFFF, 100, 32'h1111_1111, 0, 8, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 14'h2AAA, 32'h8000_0001, 7,   32'h2222_2222, 0, 8, 1'b0, 32'h0};

    // Reset values
    #1 nRst = 1'b0;
    #12;
    check("reset_outputs",
          64'({RspValid, RspTimeout, Busy, RamBusnCs, RamBusLatch, RamBusWrnRd}), 64'(0));
    check("reset_rsp_data", 64'(RspData), 64'(0));
    check("reset_bus_addr_data", 64'({RamBusAddress, RamBusDataIn}), 64'(0));
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'({CmdReady, Busy}), 64'(2'b10));

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_delay, vecs[i].rdata,
              vecs[i].rsp_wait, 1'b0, 1'b0, '0, '0, o);
      check_txn(o, vecs[i].exp_latch, vecs[i].exp_to, vecs[i].exp_data);
    end

    // Response back-pressure with a second command waiting on CmdValid
    run_txn(1'b0, 14'h0123, 32'h0, 0, 32'h5555_AAAA, 10, 1'b1, 1'b1, 14'h0321, 32'hFEED_FACE, o);
    check_txn(o, 1, 1'b0, 32'h5555_AAAA);
    run_txn(1'b1, 14'h0321, 32'hFEED_FACE, 2, 32'h0, 0, 1'b0, 1'b0, '0, '0, o);
    check_txn(o, 3, 1'b0, 32'h0);

    // Asynchronous reset in the middle of ACCESS
    CmdValid = 1'b1; CmdWrnRd = 1'b0; CmdAddress = 14'h0ABC; CmdData = '0;
    @(posedge clk);
    @(negedge clk);
    CmdValid = 1'b0;
    RamBusAck = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_latch", 64'({RamBusnCs, RamBusLatch, Busy}), 64'(3'b111));
    #2 nRst = 1'b0;
    #1;
    check("async_reset_drop", 64'({RamBusnCs, RamBusLatch, RspValid, Busy}), 64'(0));
    @(negedge clk);
    nRst = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (RspValid !== 1'b0 || CmdReady !== 1'b1 || RamBusnCs !== 1'b0) quiet = 1'b0;
    end
    check("post_reset_idle", 64'(quiet), 64'(1));
    run_txn(1'b0, 14'h0ABC, 32'h0, 1, 32'h0F0F_0F0F, 0, 1'b0, 1'b0, '0, '0, o);
    check_txn(o, 2, 1'b0, 32'h0F0F_0F0F);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rdata;
      int            d, rw;
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom);
      wdata = $urandom;
      rdata = $urandom;
      d     = int'($urandom_range(0, 11));
      rw    = int'($urandom_range(0, 3));
      model(wr, d, rdata, el, eto, ed);
      run_txn(wr, addr, wdata, d, rdata, rw, 1'b0, 1'b0, '0, '0, o);
      check_txn(o, el, eto, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
